// File: rtl/bus_pkg.sv
// Shared serial-bus definitions: slave FSM states, default widths, header length.
package bus_pkg;

  localparam int unsigned ADDR_LEN_DEF  = 12;
  localparam int unsigned DATA_LEN_DEF  = 8;
  localparam int unsigned BURST_LEN_DEF = 12;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WDATA,
    WMEM,
    RFETCH,
    RLOAD,
    RDATA,
    DONE
  } state_t;

  // Address and burst count travel side by side, so the header lasts as long as the wider field
  function automatic int unsigned hdr_len(input int unsigned addr_len,
                                          input int unsigned burst_len);
    return (addr_len > burst_len) ? addr_len : burst_len;
  endfunction

endpackage

// File: rtl/slave_out_port.sv
// Parallel-load, LSB-first serializer for read data; stalls while master_ready is low.
module slave_out_port
  import bus_pkg::*;
#(
  parameter int unsigned DATA_LEN = DATA_LEN_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [DATA_LEN-1:0] load_data,
  input  logic                active,
  input  logic                master_ready,
  output logic                tx_bit,
  output logic                last_bit
);

  localparam int unsigned CW = $clog2(DATA_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_LEN - 1);

  logic [DATA_LEN-1:0] shreg;
  logic [CW-1:0]       cnt;
  logic                shift;

  assign shift    = active & master_ready;
  assign tx_bit   = shreg[0];
  assign last_bit = shift & (cnt == LAST);

  // Load a fresh word, or shift one bit out per accepted handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= load_data;
      cnt   <= '0;
    end else if (shift) begin
      shreg <= shreg >> 1;
      cnt   <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/slave_port.sv
// Serial-bus slave endpoint: deserializes header/write data, drives a local
// synchronous memory for single or burst accesses, serializes read data back.
module slave_port
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_LEN  = ADDR_LEN_DEF,
  parameter int unsigned DATA_LEN  = DATA_LEN_DEF,
  parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                slave_en,
  input  logic                master_valid,
  input  logic                master_ready,
  input  logic                write_en,
  input  logic                read_en,
  input  logic                rx_address,
  input  logic                rx_burst_num,
  input  logic                rx_data,
  output logic                slave_ready,
  output logic                slave_valid,
  output logic                tx_data,
  output logic                trans_done,
  output logic [ADDR_LEN-1:0] mem_address,
  output logic [DATA_LEN-1:0] mem_wr_data,
  output logic                mem_wr_en,
  output logic                mem_rd_en,
  input  logic [DATA_LEN-1:0] mem_rd_data
);

  localparam int unsigned HDR_LEN = hdr_len(ADDR_LEN, BURST_LEN);
  localparam int unsigned HCW     = $clog2(HDR_LEN + 1);
  localparam int unsigned DCW     = $clog2(DATA_LEN + 1);

  localparam logic [HCW-1:0] HDR_LAST  = HCW'(HDR_LEN - 1);
  localparam logic [HCW-1:0] ADDR_BITS = HCW'(ADDR_LEN);
  localparam logic [HCW-1:0] BRST_BITS = HCW'(BURST_LEN);
  localparam logic [DCW-1:0] DATA_LAST = DCW'(DATA_LEN - 1);

  state_t state, next_state, hdr_dst;

  logic                 is_wr;
  logic [ADDR_LEN-1:0]  addr_sh, addr_nxt, base;
  logic [BURST_LEN-1:0] burst_sh, burst_nxt, count, idx;
  logic [DATA_LEN-1:0]  data_sh, data_nxt;
  logic [HCW-1:0]       hdr_cnt;
  logic [DCW-1:0]       data_cnt;

  logic start, abort, rx_take, hdr_take, hdr_last, data_take, data_last, idx_last;
  logic ser_bit, ser_last;

  assign start     = slave_en & master_valid & (write_en ^ read_en);
  assign abort     = (state != IDLE) & ~slave_en;
  assign rx_take   = master_valid & slave_ready;
  assign hdr_take  = rx_take & (((state == IDLE) & start) | (state == HDR));
  assign hdr_last  = hdr_take & (hdr_cnt == HDR_LAST);
  assign data_take = rx_take & (state == WDATA);
  assign data_last = data_take & (data_cnt == DATA_LAST);
  assign idx_last  = ((idx + BURST_LEN'(1)) == count);

  // Fields shift in LSB first and freeze once their own width is filled
  assign addr_nxt  = (hdr_cnt < ADDR_BITS) ? ADDR_LEN'({rx_address, addr_sh} >> 1) : addr_sh;
  assign burst_nxt = (hdr_cnt < BRST_BITS) ? BURST_LEN'({rx_burst_num, burst_sh} >> 1) : burst_sh;
  assign data_nxt  = DATA_LEN'({rx_data, data_sh} >> 1);

  // Direction is not latched yet when the header is one bit long and ends in IDLE
  assign hdr_dst = (state == IDLE) ? (write_en ? WDATA : RFETCH) : (is_wr ? WDATA : RFETCH);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; losing slave_en overrides every transition
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = hdr_last ? hdr_dst : HDR;
      HDR:     if (hdr_last) next_state = hdr_dst;
      WDATA:   if (data_last) next_state = WMEM;
      WMEM:    next_state = idx_last ? DONE : WDATA;
      RFETCH:  next_state = RLOAD;
      RLOAD:   next_state = RDATA;
      RDATA:   if (ser_last) next_state = idx_last ? DONE : RFETCH;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  // Output decode; strobes are suppressed in an abort or reset cycle
  always_comb begin
    logic strobe_ok;
    strobe_ok   = slave_en & ~reset;
    slave_ready = (state == IDLE) | (state == HDR) | (state == WDATA);
    slave_valid = (state == RDATA);
    tx_data     = (state == RDATA) ? ser_bit : 1'b0;
    mem_wr_en   = (state == WMEM) & strobe_ok;
    mem_rd_en   = (state == RFETCH) & strobe_ok;
    trans_done  = (state == DONE) & strobe_ok;
    mem_address = '0;
    mem_wr_data = '0;
    if ((state == WMEM) || (state == RFETCH)) mem_address = base + ADDR_LEN'(idx);
    if (state == WMEM) mem_wr_data = data_sh;
  end

  // Header/write-data deserialization, burst base/count/index bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      is_wr    <= 1'b0;
      addr_sh  <= '0;
      burst_sh <= '0;
      data_sh  <= '0;
      hdr_cnt  <= '0;
      data_cnt <= '0;
      base     <= '0;
      count    <= '0;
      idx      <= '0;
    end else if (abort) begin
      hdr_cnt  <= '0;
      data_cnt <= '0;
      idx      <= '0;
    end else begin
      if ((state == IDLE) && start) is_wr <= write_en;
      if (hdr_take) begin
        addr_sh  <= addr_nxt;
        burst_sh <= burst_nxt;
        hdr_cnt  <= hdr_last ? '0 : hdr_cnt + HCW'(1);
      end
      if (hdr_last) begin
        base  <= addr_nxt;
        count <= (burst_nxt == '0) ? BURST_LEN'(1) : burst_nxt;
        idx   <= '0;
      end
      if (data_take) begin
        data_sh  <= data_nxt;
        data_cnt <= data_last ? '0 : data_cnt + DCW'(1);
      end
      if (((state == WMEM) || ((state == RDATA) && ser_last)) && !idx_last)
        idx <= idx + BURST_LEN'(1);
    end
  end

  slave_out_port #(
    .DATA_LEN(DATA_LEN)
  ) u_out (
    .clk         (clk),
    .reset       (reset),
    .load        (state == RLOAD),
    .load_data   (mem_rd_data),
    .active      (state == RDATA),
    .master_ready(master_ready),
    .tx_bit      (ser_bit),
    .last_bit    (ser_last)
  );

endmodule

// File: tb/tb_slave_port.sv
// Directed bench for slave_port with a small synchronous memory model.
module tb_slave_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        slave_en = 1'b0;
  logic        master_valid = 1'b0;
  logic        master_ready = 1'b0;
  logic        write_en = 1'b0;
  logic        read_en = 1'b0;
  logic        rx_address = 1'b0;
  logic        rx_burst_num = 1'b0;
  logic        rx_data = 1'b0;
  logic        slave_ready, slave_valid, tx_data, trans_done;
  logic [11:0] mem_address;
  logic [7:0]  mem_wr_data;
  logic        mem_wr_en, mem_rd_en;
  logic [7:0]  mem_rd_data = 8'h00;

  slave_port #(
    .ADDR_LEN (12),
    .DATA_LEN (8),
    .BURST_LEN(12)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .slave_en    (slave_en),
    .master_valid(master_valid),
    .master_ready(master_ready),
    .write_en    (write_en),
    .read_en     (read_en),
    .rx_address  (rx_address),
    .rx_burst_num(rx_burst_num),
    .rx_data     (rx_data),
    .slave_ready (slave_ready),
    .slave_valid (slave_valid),
    .tx_data     (tx_data),
    .trans_done  (trans_done),
    .mem_address (mem_address),
    .mem_wr_data (mem_wr_data),
    .mem_wr_en   (mem_wr_en),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_data (mem_rd_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;

  logic [7:0]  rmem [4096];
  logic [11:0] wa[$];
  logic [7:0]  wd[$];
  int          wc[$];
  int          dc[$];
  logic [7:0]  wdata [4];
  int          start_cyc, hdr_end_cyc, gap_cnt;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Read port: data appears one cycle after the strobe
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= rmem[mem_address];

  // Log write strobes and completions mid-cycle
  always @(negedge clk) begin
    if (mem_wr_en) begin
      wa.push_back(mem_address);
      wd.push_back(mem_wr_data);
      wc.push_back(cyc_n);
    end
    if (trans_done) dc.push_back(cyc_n);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr();
    wa.delete(); wd.delete(); wc.delete(); dc.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check_eq({tag, "_ready"}, 32'(slave_ready), 32'd1);
    check_eq({tag, "_valid"}, 32'(slave_valid), 32'd0);
    check_eq({tag, "_tx"},    32'(tx_data), 32'd0);
    check_eq({tag, "_done"},  32'(trans_done), 32'd0);
    check_eq({tag, "_wren"},  32'(mem_wr_en), 32'd0);
    check_eq({tag, "_rden"},  32'(mem_rd_en), 32'd0);
    check_eq({tag, "_addr"},  32'(mem_address), 32'd0);
    check_eq({tag, "_wdat"},  32'(mem_wr_data), 32'd0);
  endtask

  // Drive header (and write data) bits with handshake; stop>0 ends after that many captured bits
  task automatic send(input bit wr, input logic [11:0] a, input logic [11:0] b,
                      input int n, input bit gaps, input int stop);
    int total, k, c;
    bit mv, take;
    total = (stop > 0) ? stop : 12 + (wr ? 8 * n : 0);
    k = 0; c = 0; gap_cnt = 0;
    write_en = wr;
    read_en  = !wr;
    while (k < total && c < 1000) begin
      mv = !(gaps && (c % 3 == 2));
      master_valid = mv;
      if (!mv) gap_cnt++;
      if (k < 12) begin
        rx_address = a[k]; rx_burst_num = b[k]; rx_data = 1'b0;
      end else begin
        rx_address = 1'b0; rx_burst_num = 1'b0;
        rx_data = wdata[(k - 12) / 8][(k - 12) % 8];
      end
      @(negedge clk);
      take = mv && slave_ready;
      if (take && k == 0)  start_cyc = cyc_n;
      if (take && k == 11) hdr_end_cyc = cyc_n;
      step();
      if (take) k++;
      c++;
    end
    master_valid = 1'b0; write_en = 1'b0; read_en = 1'b0;
    rx_address = 1'b0; rx_burst_num = 1'b0; rx_data = 1'b0;
    check_eq("send_bits", 32'(k), 32'(total));
  endtask

  bit exp_seq [16] = '{0,1,0,1,1,0,1,0, 1,1,0,0,0,0,1,1};

  initial begin
    logic [11:0] exp_a [3];
    logic [7:0]  exp_d [3];
    bit          got_bits[$];
    int          holds, fv_cyc, guard;
    bit          prev_hold, prev_bit;

    rmem[12'h010] = 8'h5A;
    rmem[12'h011] = 8'hC3;

    // Power-on reset
    idle(2);
    check_reset_outputs("por");
    reset = 1'b0;
    slave_en = 1'b1;
    idle(2);

    // Single write, no gaps
    clr();
    wdata[0] = 8'h3C;
    send(1'b1, 12'h0A5, 12'd1, 1, 1'b0, 0);
    idle(4);
    check_eq("w1_count", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      check_eq("w1_addr", 32'(wa[0]), 32'h0A5);
      check_eq("w1_data", 32'(wd[0]), 32'h3C);
      check_eq("w1_lat",  32'(wc[0] - start_cyc), 32'd20);
    end
    check_eq("w1_done_n", 32'(dc.size()), 32'd1);
    if (dc.size() == 1 && wc.size() == 1) check_eq("w1_done_lat", 32'(dc[0] - wc[0]), 32'd1);

    // Burst of 3 wrapping past the top of the address space
    clr();
    wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33;
    exp_a = '{12'hFFE, 12'hFFF, 12'h000};
    exp_d = '{8'h11, 8'h22, 8'h33};
    send(1'b1, 12'hFFE, 12'd3, 3, 1'b0, 0);
    idle(4);
    check_eq("w3_count", 32'(wa.size()), 32'd3);
    for (int i = 0; i < 3 && i < wa.size(); i++) begin
      check_eq("w3_addr", 32'(wa[i]), 32'(exp_a[i]));
      check_eq("w3_data", 32'(wd[i]), 32'(exp_d[i]));
    end
    check_eq("w3_done_n", 32'(dc.size()), 32'd1);

    // Read burst 2 with master_ready toggling
    clr();
    send(1'b0, 12'h010, 12'd2, 0, 1'b0, 0);
    holds = 0; fv_cyc = -1; guard = 0; prev_hold = 0; prev_bit = 0;
    master_ready = 1'b1;
    while (got_bits.size() < 16 && guard < 200) begin
      @(negedge clk);
      if (slave_valid) begin
        if (fv_cyc < 0) fv_cyc = cyc_n;
        if (prev_hold && (tx_data != prev_bit)) holds++;
        if (master_ready) begin
          got_bits.push_back(tx_data);
          prev_hold = 0;
        end else begin
          prev_hold = 1;
          prev_bit  = tx_data;
        end
      end else begin
        prev_hold = 0;
      end
      step();
      master_ready = ~master_ready;
      guard++;
    end
    master_ready = 1'b0;
    idle(4);
    check_eq("r_nbits", 32'(got_bits.size()), 32'd16);
    for (int i = 0; i < 16 && i < got_bits.size(); i++)
      check_eq($sformatf("r_bit%0d", i), 32'(got_bits[i]), 32'(exp_seq[i]));
    check_eq("r_holds", 32'(holds), 32'd0);
    check_eq("r_first_valid", 32'(fv_cyc - hdr_end_cyc), 32'd3);
    check_eq("r_no_write", 32'(wa.size()), 32'd0);
    check_eq("r_done_n", 32'(dc.size()), 32'd1);

    // Write with a valid gap every third cycle, burst_num 0
    clr();
    wdata[0] = 8'h3C;
    send(1'b1, 12'h0A5, 12'd0, 1, 1'b1, 0);
    idle(4);
    check_eq("wg_count", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      check_eq("wg_addr", 32'(wa[0]), 32'h0A5);
      check_eq("wg_data", 32'(wd[0]), 32'h3C);
      check_eq("wg_lat",  32'(wc[0] - start_cyc), 32'(20 + gap_cnt));
    end
    check_eq("wg_done_n", 32'(dc.size()), 32'd1);

    // slave_en dropped after 4 data bits
    clr();
    wdata[0] = 8'hFF;
    send(1'b1, 12'h123, 12'd1, 1, 1'b0, 16);
    slave_en = 1'b0;
    idle(2);
    slave_en = 1'b1;
    idle(3);
    @(negedge clk);
    check_eq("ab_ready", 32'(slave_ready), 32'd1);
    check_eq("ab_valid", 32'(slave_valid), 32'd0);
    check_eq("ab_write", 32'(wa.size()), 32'd0);
    check_eq("ab_done",  32'(dc.size()), 32'd0);
    step();

    // Both enables set in IDLE: ignored, then a normal write still lines up
    clr();
    write_en = 1'b1; read_en = 1'b1; master_valid = 1'b1; rx_address = 1'b1; rx_burst_num = 1'b1;
    idle(14);
    write_en = 1'b0; read_en = 1'b0; master_valid = 1'b0; rx_address = 1'b0; rx_burst_num = 1'b0;
    idle(2);
    check_eq("both_write", 32'(wa.size()), 32'd0);
    check_eq("both_done",  32'(dc.size()), 32'd0);
    wdata[0] = 8'hAA;
    send(1'b1, 12'h055, 12'd1, 1, 1'b0, 0);
    idle(4);
    check_eq("both_after_n", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      check_eq("both_after_addr", 32'(wa[0]), 32'h055);
      check_eq("both_after_data", 32'(wd[0]), 32'hAA);
      check_eq("both_after_lat",  32'(wc[0] - start_cyc), 32'd20);
    end

    // Reset asserted in the cycle that would strobe the write
    clr();
    wdata[0] = 8'h3C;
    send(1'b1, 12'h0A5, 12'd1, 1, 1'b0, 0);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_no_strobe", 32'(mem_wr_en), 32'd0);
    step();
    check_reset_outputs("rst");
    step();
    reset = 1'b0;
    idle(4);
    check_eq("rst_write", 32'(wa.size()), 32'd0);
    check_eq("rst_done",  32'(dc.size()), 32'd0);

    // Normal write after mid-transaction reset
    clr();
    wdata[0] = 8'h81;
    send(1'b1, 12'h3FF, 12'd1, 1, 1'b0, 0);
    idle(4);
    check_eq("post_n", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      check_eq("post_addr", 32'(wa[0]), 32'h3FF);
      check_eq("post_data", 32'(wd[0]), 32'h81);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
